// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned IF_ADDR_W   = 32;
  localparam int unsigned IF_DATA_W   = 32;
  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [IF_ADDR_W-1:0] IF_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } ifetch_state_e;

  typedef struct packed {
    logic [IF_ADDR_W-1:0] pc;
    logic [IF_DATA_W-1:0] data;
  } ifetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, data} entries; flush wins over push/pop.
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;
  logic             w_push;

  // Pop needs an entry; a push into a full queue is only legal alongside a pop.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, one-outstanding request FSM with credit flow control, redirect flush.
// Optional IFETCH_MISALIGN_TRAP_EN: misaligned redirect raises sticky fetch_misaligned and halts fetch.
module instr_fetch
  import ifetch_pkg::*;
#(
  parameter int unsigned            ADDR_W   = IF_ADDR_W,
  parameter int unsigned            DATA_W   = IF_DATA_W,
  parameter logic [ADDR_W-1:0]      RESET_PC = ADDR_W'(IF_RESET_PC),
  parameter int unsigned            Q_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready
`ifdef IFETCH_MISALIGN_TRAP_EN
  , output logic            fetch_misaligned
`endif
);

  localparam int unsigned CNT_W = $clog2(Q_DEPTH + 1);

  ifetch_state_e     r_state;
  ifetch_state_e     w_state_nxt;
  ifetch_state_e     w_resume;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_pc;
  logic              r_req_valid;
  logic              w_hs;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_outstanding;
  logic              w_credit;
  logic              w_credit_after;
  logic              w_trap;
  logic              w_trap_nxt;
  logic [CNT_W-1:0]  w_count;
  ifetch_entry_t     w_push_entry;
  ifetch_entry_t     w_head;

  assign w_hs          = r_req_valid & imem_req_ready;
  assign w_pop         = inst_valid & inst_ready;
  assign w_outstanding = (r_state == WAIT) || (r_state == DROP);
  assign w_credit       = (32'(w_count) + 32'(w_outstanding)) < Q_DEPTH;
  assign w_credit_after = (32'(w_count) + 32'd1 - 32'(w_pop)) < Q_DEPTH;
  assign w_resume       = w_trap_nxt ? IDLE : REQ;

`ifdef IFETCH_MISALIGN_TRAP_EN
  logic r_trap;

  assign w_trap_nxt = r_trap | (redirect_valid & (redirect_pc[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_trap <= 1'b0;
    else        r_trap <= w_trap_nxt;
  end

  assign w_trap           = r_trap;
  assign fetch_misaligned = r_trap;
`else
  assign w_trap     = 1'b0;
  assign w_trap_nxt = 1'b0;
`endif

  // Next state, PC and queue control; a redirect overrides the normal flow.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    case (r_state)
      IDLE: if (w_credit && !w_trap) w_state_nxt = REQ;
      REQ: begin
        if (w_hs) begin
          w_state_nxt = WAIT;
          w_pc_nxt    = r_pc + ADDR_W'(INSTR_BYTES);
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = w_credit_after ? REQ : IDLE;
        end
      end
      DROP:    if (imem_rsp_valid) w_state_nxt = w_trap ? IDLE : REQ;
      default: w_state_nxt = IDLE;
    endcase
    if (redirect_valid) begin
      w_flush  = 1'b1;
      w_push   = 1'b0;
      w_pc_nxt = redirect_pc & ~ADDR_W'(3);
      case (r_state)
        REQ:     w_state_nxt = w_hs ? DROP : w_resume;
        WAIT:    w_state_nxt = imem_rsp_valid ? w_resume : DROP;
        DROP:    w_state_nxt = imem_rsp_valid ? w_resume : DROP;
        default: w_state_nxt = w_resume;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_pc        <= RESET_PC;
      r_req_pc    <= RESET_PC;
      r_req_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_valid <= (w_state_nxt == REQ);
      if (w_hs) r_req_pc <= r_pc;
    end
  end

  assign w_push_entry.pc   = IF_ADDR_W'(r_req_pc);
  assign w_push_entry.data = IF_DATA_W'(imem_rsp_data);

  fetch_queue #(
    .DEPTH (Q_DEPTH),
    .WIDTH ($bits(ifetch_entry_t))
  ) u_queue (
    .clk     (clk),
    .rst_n   (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = (w_count != '0);
  assign inst_pc        = ADDR_W'(w_head.pc);
  assign inst_data      = DATA_W'(w_head.data);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed table-driven bench for instr_fetch; memory model answers with ~addr after mem_lat cycles.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  instr_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
`ifdef IFETCH_MISALIGN_TRAP_EN
    , .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  // In-order memory with one response per accepted request, mem_lat cycles later.
  int unsigned mem_lat = 1;
  int unsigned mem_cnt;
  logic [31:0] mem_addr;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_cnt  <= 0;
      mem_addr <= '0;
    end else if (imem_req_valid && imem_req_ready) begin
      mem_cnt  <= mem_lat;
      mem_addr <= imem_req_addr;
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
    end
  end

  assign imem_rsp_valid = (mem_cnt == 1);
  assign imem_rsp_data  = ~mem_addr;

  typedef struct {
    logic        first;
    int unsigned lat;
    logic        ready;
    logic        ir;
    logic        redir;
    logic [31:0] rpc;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ipc;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   row = -1;

  function automatic vec_t v(input logic first, input int unsigned lat, input logic ready,
                             input logic ir, input logic redir, input logic [31:0] rpc,
                             input logic rv, input logic [31:0] addr, input logic iv,
                             input logic [31:0] ipc);
    vec_t t;
    t.first = first; t.lat = lat; t.ready = ready; t.ir = ir; t.redir = redir;
    t.rpc = rpc; t.rv = rv; t.addr = addr; t.iv = iv; t.ipc = ipc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row=%0d t=%0t: got %h, expected %h", name, row, $time, act, exp);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'h0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_data", inst_data, 32'h0);
`ifdef IFETCH_MISALIGN_TRAP_EN
    chk("rst_misaligned", 32'(fetch_misaligned), 32'd0);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs();
    reset = 1'b1;
  endtask

  initial begin
    // Straight-line fetch, 1-cycle memory, decode always ready.
    tbl.push_back(v(1, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h4, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h8, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h8, 1, 32'h4));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'hC, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'hC, 1, 32'h8));
    // Decode stalled: queue fills after two words, fetch idles, then resumes at 0x8.
    tbl.push_back(v(1, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h4, 0, 0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 32'h4, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 0, 0, 0, 0, 32'h8, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h8, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h8, 1, 32'h4));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h8, 0, 0));
    // Redirect to 0x100 while waiting on 0x4 (2-cycle memory): 0x4 word dropped.
    tbl.push_back(v(1, 2, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 0, 32'h4, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 0, 32'h4, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0));
    tbl.push_back(v(0, 2, 1, 1, 1, 32'h100, 0, 32'h8, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 0, 32'h100, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 0, 32'h104, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 0, 32'h104, 0, 0));
    tbl.push_back(v(0, 2, 1, 1, 0, 0, 1, 32'h104, 1, 32'h100));
    // Redirect to 0x200 on the handshake of 0x8: 0x8 word never delivered.
    tbl.push_back(v(1, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h4, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h4, 1, 32'h0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h8, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 1, 32'h200, 1, 32'h8, 1, 32'h4));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h200, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h200, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h204, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h204, 1, 32'h200));
    // PC wrap from 0xFFFF_FFFC to 0.
    tbl.push_back(v(1, 1, 1, 1, 1, 32'hFFFF_FFFC, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC));
    // Misaligned redirect to 0x102.
    tbl.push_back(v(1, 1, 1, 1, 1, 32'h102, 0, 32'h0, 0, 0));
`ifdef IFETCH_MISALIGN_TRAP_EN
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h100, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h100, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h100, 0, 0));
`else
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h100, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 0, 32'h104, 0, 0));
    tbl.push_back(v(0, 1, 1, 1, 0, 0, 1, 32'h104, 1, 32'h100));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].first) do_reset();
      row            = i;
      mem_lat        = tbl[i].lat;
      imem_req_ready = tbl[i].ready;
      inst_ready     = tbl[i].ir;
      redirect_valid = tbl[i].redir;
      redirect_pc    = tbl[i].rpc;
      chk("req_valid", 32'(imem_req_valid), 32'(tbl[i].rv));
      chk("req_addr", imem_req_addr, tbl[i].addr);
      chk("inst_valid", 32'(inst_valid), 32'(tbl[i].iv));
      if (tbl[i].iv) begin
        chk("inst_pc", inst_pc, tbl[i].ipc);
        chk("inst_data", inst_data, ~tbl[i].ipc);
      end
      @(negedge clk);
    end

`ifdef IFETCH_MISALIGN_TRAP_EN
    row = -2;
    chk("misaligned_sticky", 32'(fetch_misaligned), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("trap_no_req", 32'(imem_req_valid), 32'd0);
    chk("misaligned_hold", 32'(fetch_misaligned), 32'd1);
`endif

    // Asynchronous reset in the middle of a fetch with a word queued.
    row = -3;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; mem_lat = 1;
    repeat (4) @(negedge clk);
    chk("pre_rst_inst_data", inst_data, 32'hFFFF_FFFF);
    @(posedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);
    chk("post_rst_req_addr", imem_req_addr, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
